// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: function codes,
// FSM encoding and sign helpers used by the iterative datapath.
package hilo_mdu_pkg;

    localparam int MDU_W = 32;

    localparam logic [4:0] FS_MULT = 5'h1E;
    localparam logic [4:0] FS_DIV  = 5'h1F;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // |0x8000_0000| stays 0x8000_0000, read as unsigned.
    function automatic logic [MDU_W-1:0] mag32(input logic [MDU_W-1:0] v);
        return v[MDU_W-1] ? -v : v;
    endfunction

    function automatic logic [MDU_W-1:0] cond_neg32(input logic [MDU_W-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*MDU_W-1:0] cond_neg64(input logic [2*MDU_W-1:0] v,
                                                      input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// Execute-stage connection to the multiply/divide unit: operands, function
// select and HI/LO moves in; status flags and HI/LO out.
interface hilo_mdu_if #(parameter int WIDTH = 32);
    logic             start;
    logic [4:0]       FS;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] T;
    logic             mthi;
    logic             mtlo;
    logic             busy;
    logic             done;
    logic             dz;
    logic             N;
    logic             Z;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, FS, S, T, mthi, mtlo,
        input  busy, done, dz, N, Z, HI, LO
    );

    modport slave (
        input  start, FS, S, T, mthi, mtlo,
        output busy, done, dz, N, Z, HI, LO
    );
endinterface

// File: rtl/hilo_mdu.sv
// Iterative signed MULT/DIV engine with architectural HI/LO registers:
// one bit per clock (shift-add / restoring), then a sign fix-up cycle.
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    hilo_mdu_if.slave   bus
);

    state_e state_q, state_d;

    logic [4:0]         cnt_q;
    logic               is_div_q;
    logic               dz_op_q;
    logic               sign_q;      // product sign for MULT, quotient sign for DIV
    logic               rsign_q;
    logic [WIDTH-1:0]   s_raw_q;
    logic [WIDTH-1:0]   mag_b_q;     // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc_q;       // product accumulator; low half is quotient in DIV
    logic [WIDTH-1:0]   rem_q;

    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q, dz_q, n_q, z_q;

    logic               accept, do_mthi, do_mtlo;
    logic               fs_mult, fs_div, t_zero;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] mul_fix;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    assign fs_mult = (bus.FS == FS_MULT);
    assign fs_div  = (bus.FS == FS_DIV);
    assign t_zero  = (bus.T == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // DONE behaves like IDLE for start so back-to-back operations need no bubble.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        do_mthi = 1'b0;
        do_mtlo = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start && (fs_mult || fs_div)) begin
                    accept = 1'b1;
                    if (fs_mult)     state_d = ST_MUL;
                    else if (t_zero) state_d = ST_FIX;
                    else             state_d = ST_DIV;
                end else begin
                    state_d = ST_IDLE;
                    if (state_q == ST_IDLE) begin
                        do_mthi = bus.mthi;
                        do_mtlo = bus.mtlo;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == 5'd0) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, mag_b_q};
        mul_fix   = cond_neg64(acc_q, sign_q);
        if (dz_op_q) begin
            hi_fix = s_raw_q;
            lo_fix = '1;
        end else if (is_div_q) begin
            hi_fix = cond_neg32(rem_q, rsign_q);
            lo_fix = cond_neg32(acc_q[WIDTH-1:0], sign_q);
        end else begin
            hi_fix = mul_fix[2*WIDTH-1:WIDTH];
            lo_fix = mul_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            dz_op_q  <= 1'b0;
            sign_q   <= 1'b0;
            rsign_q  <= 1'b0;
            s_raw_q  <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            if (accept) begin
                cnt_q    <= 5'd31;
                is_div_q <= fs_div;
                dz_op_q  <= fs_div && t_zero;
                sign_q   <= bus.S[WIDTH-1] ^ bus.T[WIDTH-1];
                rsign_q  <= bus.S[WIDTH-1];
                s_raw_q  <= bus.S;
                mag_b_q  <= fs_mult ? mag32(bus.S) : mag32(bus.T);
                acc_q    <= {{WIDTH{1'b0}}, fs_mult ? mag32(bus.T) : mag32(bus.S)};
                rem_q    <= '0;
                dz_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_MUL: begin
                        acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                        cnt_q <= cnt_q - 5'd1;
                    end
                    ST_DIV: begin
                        if (!div_trial[WIDTH]) begin
                            rem_q               <= div_trial[WIDTH-1:0];
                            acc_q[WIDTH-1:0]    <= {acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_q               <= div_shift[WIDTH-1:0];
                            acc_q[WIDTH-1:0]    <= {acc_q[WIDTH-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q - 5'd1;
                    end
                    ST_FIX: begin
                        hi_q <= hi_fix;
                        lo_q <= lo_fix;
                        n_q  <= is_div_q ? lo_fix[WIDTH-1] : hi_fix[WIDTH-1];
                        z_q  <= (hi_fix == '0) && (lo_fix == '0);
                        dz_q <= dz_op_q;
                    end
                    default: begin
                        if (do_mthi) hi_q <= bus.S;
                        if (do_mtlo) lo_q <= bus.S;
                    end
                endcase
            end
            busy_q <= (state_d == ST_MUL) || (state_d == ST_DIV) || (state_d == ST_FIX);
            done_q <= (state_d == ST_DONE);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.N    = n_q;
    assign bus.Z    = z_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule
